aes_job_arbiter: RTL and testbench
==================================

AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, max cycles waited for core_done after core_start (legal range 2..255).
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid, req1_valid  in  1 each  requester has a job.
REQ-005 SHALL have ports: req0_ready, req1_ready  out  1 each  job accepted this cycle.
REQ-006 SHALL have ports: req0_text, req1_text  in  128 each  ciphertext block.
REQ-007 SHALL have ports: req0_key, req1_key  in  128 each  cipher key.
REQ-008 SHALL have port: core_start  out  1  one-cycle launch pulse to the shared decrypt core.
REQ-009 SHALL have ports: core_text, core_key  out  128 each  latched job operands, stable from launch until response.
REQ-010 SHALL have port: core_done  in  1  one-cycle completion pulse from the core.
REQ-011 SHALL have port: core_result  in  128  plaintext; valid only while core_done=1.
REQ-012 SHALL have ports: rsp_valid  out  1 and rsp_ready  in  1  response handshake.
REQ-013 SHALL have ports: rsp_data  out  128, rsp_id  out  1 (source requester), rsp_err  out  1 (timeout).

Function
REQ-014 SHALL implement FSM with states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: grant = the only valid requester; if both are valid, the one differing from last_grant; reqN_ready=1 only for the granted requester, only in IDLE, combinationally.
REQ-016 On handshake (reqN_valid & reqN_ready), SHALL latch text, key and id into core_text/core_key/rsp_id, then go to ISSUE.
REQ-017 ISSUE: core_start=1 for exactly that cycle; clear timer; go to WAIT.
REQ-018 WAIT: timer increments each cycle; on core_done, latch core_result into rsp_data, set rsp_err=0, go to RESP.
REQ-019 WAIT: if the timer reaches TIMEOUT_CYCLES-1 without core_done, set rsp_data=0 and rsp_err=1, then go to RESP.
REQ-020 If core_done coincides with the timeout cycle, done SHALL win (rsp_err=0).
REQ-021 RESP: rsp_valid=1; rsp_data, rsp_id and rsp_err held stable until rsp_ready=1.
REQ-022 On rsp_valid & rsp_ready, SHALL set last_grant=rsp_id, deassert rsp_valid next cycle, and go to IDLE.
REQ-023 core_done outside WAIT SHALL be ignored (no state or data change).
REQ-024 Latency: handshake at cycle T -> core_start at T+1 -> done at T+1+N -> rsp_valid at T+2+N; back-to-back acceptance possible the cycle after the response handshake.
REQ-025 A requester dropping valid before handshake SHALL lose nothing; no grant is held across IDLE cycles.
REQ-026 Only one job SHALL be outstanding at any time; no reqN_ready outside IDLE.

Reset
REQ-027 rst SHALL force IDLE; core_start, rsp_valid, rsp_err, reqN_ready=0; rsp_data, core_text, core_key=0; rsp_id=0; timer=0; last_grant=1 (req0 wins the first tie).
REQ-028 rst asserted mid-job (ISSUE/WAIT/RESP) SHALL abort the job silently; a later core_done SHALL be ignored.

Verification
REQ-029 Single job: req0 text=0x69c4e0d86a7b0430d8cdb78070b4c55a, core returns 0x00112233445566778899aabbccddeeff after 12 cycles -> one core_start, rsp_valid with that data, rsp_id=0, rsp_err=0.
REQ-030 Simultaneous req0/req1 valid from reset -> req0 served first, then req1; repeated ties alternate 0,1,0,1.
REQ-031 Core never asserts done, TIMEOUT_CYCLES=8 -> rsp_valid 8 cycles after core_start with rsp_data=0, rsp_err=1.
REQ-032 rsp_ready held low 20 cycles in RESP -> rsp_* stable, no reqN_ready, no core_start.
REQ-033 rst pulsed in WAIT, then core_done -> no rsp_valid; next req1 job completes normally.
REQ-034 core_done on the exact timeout cycle -> rsp_err=0, rsp_data=core_result.

Source files
------------

// File: rtl/aes_job_arbiter.sv
// Two-requester arbiter in front of a single shared AES decrypt core.
// Alternating priority on ties, one job in flight, core-done timeout with error response.
module aes_job_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [127:0] req0_text,
    input  logic [127:0] req1_text,
    input  logic [127:0] req0_key,
    input  logic [127:0] req1_key,
    output logic         core_start,
    output logic [127:0] core_text,
    output logic [127:0] core_key,
    input  logic         core_done,
    input  logic [127:0] core_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         rsp_err
);
    localparam int unsigned TW = 8;
    // Timer starts at 0 in the first WAIT cycle, so the final WAIT cycle
    // (TIMEOUT_CYCLES-1 cycles after core_start) sees TIMEOUT_CYCLES-2.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 32'd2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic            last_grant;
    logic            grant;
    logic            timeout_hit;
    logic [TW-1:0]   timer;

    assign timeout_hit = (timer == TIMER_LAST);
    assign core_start  = (state == ISSUE);
    assign rsp_valid   = (state == RESP);

    // Next state and combinational request acceptance
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        case (state)
            IDLE: begin
                req0_ready = !rst && req0_valid && !grant;
                req1_ready = !rst && req1_valid && grant;
                if (req0_ready || req1_ready) state_next = ISSUE;
            end
            ISSUE: state_next = WAIT;
            WAIT:  if (core_done || timeout_hit) state_next = RESP;
            RESP:  if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and job/response datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            last_grant <= 1'b1;
            core_text  <= '0;
            core_key   <= '0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        core_text <= grant ? req1_text : req0_text;
                        core_key  <= grant ? req1_key  : req0_key;
                        rsp_id    <= grant;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A done on the timeout cycle still counts as success
                    if (core_done) begin
                        rsp_data <= core_result;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) last_grant <= rsp_id;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_aes_job_arbiter;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchecks = 0;
    int nerr    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        nchecks++;
        nerr++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Short-timeout instance: model-checked every cycle
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_text = '0, req1_text = '0, req0_key = '0, req1_key = '0;
    logic         core_start;
    logic [127:0] core_text, core_key;
    logic         core_done = 1'b0;
    logic [127:0] core_result = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         rsp_id, rsp_err;

    aes_job_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_text(req0_text), .req1_text(req1_text),
        .req0_key(req0_key), .req1_key(req1_key),
        .core_start(core_start), .core_text(core_text), .core_key(core_key),
        .core_done(core_done), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    // Default-timeout instance for the long-latency directed job
    logic         rst_l = 1'b1;
    logic         req0_valid_l = 1'b0, req1_valid_l = 1'b0;
    logic         req0_ready_l, req1_ready_l;
    logic [127:0] req0_text_l = '0, req1_text_l = '0, req0_key_l = '0, req1_key_l = '0;
    logic         core_start_l;
    logic [127:0] core_text_l, core_key_l;
    logic         core_done_l = 1'b0;
    logic [127:0] core_result_l = '0;
    logic         rsp_valid_l;
    logic         rsp_ready_l = 1'b0;
    logic [127:0] rsp_data_l;
    logic         rsp_id_l, rsp_err_l;

    aes_job_arbiter dut_l (
        .clk(clk), .rst(rst_l),
        .req0_valid(req0_valid_l), .req1_valid(req1_valid_l),
        .req0_ready(req0_ready_l), .req1_ready(req1_ready_l),
        .req0_text(req0_text_l), .req1_text(req1_text_l),
        .req0_key(req0_key_l), .req1_key(req1_key_l),
        .core_start(core_start_l), .core_text(core_text_l), .core_key(core_key_l),
        .core_done(core_done_l), .core_result(core_result_l),
        .rsp_valid(rsp_valid_l), .rsp_ready(rsp_ready_l),
        .rsp_data(rsp_data_l), .rsp_id(rsp_id_l), .rsp_err(rsp_err_l)
    );

    // Core emulator: answers core_start after core_lat cycles (0 = never), optional spurious dones
    int           core_lat = 5;
    bit           spur_en  = 1'b0;
    int           done_at  = -1;
    logic [127:0] done_result = '0;
    always @(negedge clk) begin
        if (core_start) done_at = (core_lat > 0) ? cyc + core_lat : -1;
        core_result = {$urandom, $urandom, $urandom, $urandom};
        core_done   = (cyc == done_at) || (spur_en && ($urandom_range(15) == 0));
        if (cyc == done_at) done_result = core_result;
    end

    // Transaction-level reference: a job is (handshake cycle, completion cycle)
    bit           m_valid = 1'b0;
    bit           m_busy;
    int           m_ths, m_resp_at;
    logic         m_lg, m_id, m_err;
    logic [127:0] m_text, m_key, m_data;

    always @(negedge clk) begin
        logic g, e_r0, e_r1, e_start, e_rv;
        #1;
        g       = (req0_valid && req1_valid) ? ~m_lg : req1_valid;
        e_r0    = !m_busy && !rst && req0_valid && !g;
        e_r1    = !m_busy && !rst && req1_valid && g;
        e_start = m_busy && (cyc == m_ths + 1);
        e_rv    = m_busy && (m_resp_at >= 0) && (cyc >= m_resp_at);
        if (m_valid) begin
            check("req0_ready", 128'(req0_ready), 128'(e_r0));
            check("req1_ready", 128'(req1_ready), 128'(e_r1));
            check("core_start", 128'(core_start), 128'(e_start));
            check("rsp_valid",  128'(rsp_valid),  128'(e_rv));
            check("core_text",  core_text, m_text);
            check("core_key",   core_key,  m_key);
            check("rsp_id",     128'(rsp_id),  128'(m_id));
            check("rsp_err",    128'(rsp_err), 128'(m_err));
            check("rsp_data",   rsp_data, m_data);
        end
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_ths = 0; m_resp_at = -1;
            m_lg = 1'b1; m_id = 1'b0; m_err = 1'b0;
            m_text = '0; m_key = '0; m_data = '0;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (e_r0 || e_r1) begin
                    m_busy = 1'b1; m_ths = cyc; m_resp_at = -1; m_id = e_r1;
                    m_text = e_r1 ? req1_text : req0_text;
                    m_key  = e_r1 ? req1_key  : req0_key;
                end
            end else if (e_rv) begin
                if (rsp_ready) begin m_busy = 1'b0; m_lg = m_id; end
            end else if (m_resp_at < 0 && cyc >= m_ths + 2) begin
                if (core_done) begin
                    m_data = core_result; m_err = 1'b0; m_resp_at = cyc + 1;
                end else if (cyc == m_ths + int'(TO)) begin
                    m_data = '0; m_err = 1'b1; m_resp_at = cyc + 1;
                end
            end
        end
    end

    // Launch one job on the short-timeout instance and wait for its response (left pending)
    task automatic run_job(input bit v0, input bit v1, input int lat,
                           output int start_c, output int rsp_c);
        @(negedge clk);
        core_lat   = lat;
        rsp_ready  = 1'b0;
        req0_valid = v0; req1_valid = v1;
        req0_text = {$urandom, $urandom, $urandom, $urandom};
        req1_text = {$urandom, $urandom, $urandom, $urandom};
        req0_key  = {$urandom, $urandom, $urandom, $urandom};
        req1_key  = {$urandom, $urandom, $urandom, $urandom};
        start_c = -1; rsp_c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            #2;
            if (core_start) start_c = cyc;
            if (rsp_valid) begin rsp_c = cyc; break; end
        end
        if (rsp_c < 0) bound_fail("run_job response");
    endtask

    task automatic finish_rsp();
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
    endtask

    initial begin
        int s, r, starts, rv_seen;
        logic [127:0] lit_text, lit_res;

        // Long-latency single job on the default-timeout instance
        lit_text = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        lit_res  = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk); rst_l = 1'b1;
        @(negedge clk); rst_l = 1'b0;
        req0_valid_l = 1'b1; req0_text_l = lit_text; req0_key_l = 128'h000102030405060708090a0b0c0d0e0f;
        #2;
        check("L ready0", 128'(req0_ready_l), 128'(1));
        @(negedge clk); req0_valid_l = 1'b0; #2;
        check("L start", 128'(core_start_l), 128'(1));
        check("L core_text", core_text_l, lit_text);
        starts = 1; rv_seen = 0;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk); #2;
            starts += int'(core_start_l); rv_seen += int'(rsp_valid_l);
        end
        @(negedge clk); core_done_l = 1'b1; core_result_l = lit_res;
        @(negedge clk); core_done_l = 1'b0; core_result_l = '1; #2;
        check("L starts", 128'(starts), 128'(1));
        check("L early rsp", 128'(rv_seen), 128'(0));
        check("L rsp_valid", 128'(rsp_valid_l), 128'(1));
        check("L rsp_data", rsp_data_l, lit_res);
        check("L rsp_id", 128'(rsp_id_l), 128'(0));
        check("L rsp_err", 128'(rsp_err_l), 128'(0));
        rsp_ready_l = 1'b1;
        @(negedge clk); rsp_ready_l = 1'b0; #2;
        check("L rsp_drop", 128'(rsp_valid_l), 128'(0));

        // Reset values on the short-timeout instance
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #2;
        check("R rsp_valid", 128'(rsp_valid), 128'(0));
        check("R core_start", 128'(core_start), 128'(0));
        check("R core_text", core_text, 128'(0));
        check("R rsp_data", rsp_data, 128'(0));

        // Ties alternate starting with req0
        for (int k = 0; k < 4; k++) begin
            run_job(1'b1, 1'b1, 3, s, r);
            check("tie id", 128'(rsp_id), 128'(k % 2));
            check("tie latency", 128'(r - s), 128'(4));
            finish_rsp();
        end

        // Timeout, then a long RESP stall with a competing request
        run_job(1'b1, 1'b0, 0, s, r);
        check("TO latency", 128'(r - s), 128'(TO));
        check("TO err", 128'(rsp_err), 128'(1));
        check("TO data", rsp_data, 128'(0));
        starts = 0; rv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); req1_valid = 1'b1; #2;
            starts += int'(core_start) + int'(req0_ready) + int'(req1_ready);
            rv_seen += int'(rsp_valid);
        end
        req1_valid = 1'b0;
        check("stall no grant", 128'(starts), 128'(0));
        check("stall valid", 128'(rv_seen), 128'(20));
        check("stall err", 128'(rsp_err), 128'(1));
        finish_rsp();

        // Done on the exact timeout cycle wins
        run_job(1'b0, 1'b1, TO - 1, s, r);
        check("edge err", 128'(rsp_err), 128'(0));
        check("edge data", rsp_data, done_result);
        check("edge latency", 128'(r - s), 128'(TO));
        finish_rsp();

        // Reset in WAIT, late done ignored, then a normal req1 job
        @(negedge clk); core_lat = 6; req0_valid = 1'b1;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #2;
            rv_seen += int'(rsp_valid);
        end
        check("abort rsp", 128'(rv_seen), 128'(0));
        run_job(1'b0, 1'b1, 4, s, r);
        check("post id", 128'(rsp_id), 128'(1));
        check("post err", 128'(rsp_err), 128'(0));
        finish_rsp();

        // Randomized traffic with spurious dones and sparse resets
        spur_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(299) == 0);
            req0_valid = ($urandom_range(2) == 0);
            req1_valid = ($urandom_range(2) == 0);
            rsp_ready  = ($urandom_range(1) == 0);
            core_lat   = int'($urandom_range(10));
            req0_text = {$urandom, $urandom, $urandom, $urandom};
            req1_text = {$urandom, $urandom, $urandom, $urandom};
            req0_key  = {$urandom, $urandom, $urandom, $urandom};
            req1_key  = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #3;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", nchecks, nerr);
        $fatal(1, "watchdog");
    end
endmodule
